// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_port_arbiter_pkg;

    // Data word width on both requester ports and the backing memory.
    localparam int WORD_LEN     = 32;

    // Requester ports carry byte addresses; the backing memory is word addressed,
    // so the two low address bits are dropped on the way out.
    localparam int BYTE_OFS_LEN = 2;
    localparam int ADDR_LEN_DEF = 32;

    function automatic int mem_addr_len(input int addr_len);
        return addr_len - BYTE_OFS_LEN;
    endfunction

    localparam int MEM_ADDR_LEN_DEF = mem_addr_len(ADDR_LEN_DEF);

    // Arbiter FSM states: one access phase and one acknowledge phase per port.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_ACC  = 3'd1,
        I_ACC  = 3'd2,
        D_RESP = 3'd3,
        I_RESP = 3'd4
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch port, data port and backing-memory signals around the arbiter.
// Latency: n/a (wires only).
// Backpressure: requests are levels held until their ack; memory request held until mem_ready.
//
// Modports:
//   slave  - arbiter view: samples requests and memory completion, drives acks,
//            read data, freeze and the memory request.
//   master - environment view (pipeline + backing memory), the mirror image.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_LEN     = ADDR_LEN_DEF,
    parameter int MEM_ADDR_LEN = mem_addr_len(ADDR_LEN)
);
    // instruction fetch port
    logic                    i_req;
    logic [ADDR_LEN-1:0]     i_addr;
    logic                    i_ack;
    // data port
    logic                    d_req;
    logic                    d_we;
    logic [ADDR_LEN-1:0]     d_addr;
    logic [WORD_LEN-1:0]     d_wdata;
    logic                    d_ack;
    // shared response / pipeline control
    logic [WORD_LEN-1:0]     rdata;
    logic                    freeze;
    // backing memory
    logic                    mem_req;
    logic                    mem_we;
    logic [MEM_ADDR_LEN-1:0] mem_addr;
    logic [WORD_LEN-1:0]     mem_wdata;
    logic [WORD_LEN-1:0]     mem_rdata;
    logic                    mem_ready;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_ack, d_ack, rdata, freeze, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_ack, d_ack, rdata, freeze, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_ibuf.sv
// One-entry instruction buffer: valid bit, word-address tag and data word with hit compare.
// Latency: hit is combinational from the stored entry; fill/invalidate take effect next cycle.
// Backpressure: none; fill and invalidate are single-cycle strobes from the arbiter FSM.
//
// Ports: clk, rst (async active-low); fill_vld/fill_tag/fill_dat load the entry;
// inv_vld/inv_tag clear it when the tag matches; lookup_tag -> hit, hit_dat.
module arb_ibuf
    import mem_port_arbiter_pkg::*;
#(
    parameter int TAG_LEN = MEM_ADDR_LEN_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fill_vld,
    input  logic [TAG_LEN-1:0]  fill_tag,
    input  logic [WORD_LEN-1:0] fill_dat,
    input  logic                inv_vld,
    input  logic [TAG_LEN-1:0]  inv_tag,
    input  logic [TAG_LEN-1:0]  lookup_tag,
    output logic                hit,
    output logic [WORD_LEN-1:0] hit_dat
);

    logic                valid_q, valid_d;
    logic [TAG_LEN-1:0]  tag_q,   tag_d;
    logic [WORD_LEN-1:0] dat_q,   dat_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        dat_d   = dat_q;
        // A store to the cached word makes the copy stale.
        if (inv_vld && (inv_tag == tag_q)) begin
            valid_d = 1'b0;
        end
        // Fill and invalidate never coincide (one access at a time), so order is moot.
        if (fill_vld) begin
            valid_d = 1'b1;
            tag_d   = fill_tag;
            dat_d   = fill_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            dat_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            dat_q   <= dat_d;
        end
    end

    assign hit     = valid_q && (tag_q == lookup_tag);
    assign hit_dat = dat_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF-stage fetches and MEM-stage loads/stores onto one variable-latency memory.
// Latency: ack k+1 cycles after the request is sampled (mem_ready at cycle k >= 1); 1 cycle on an ibuf hit.
// Backpressure: requests are held levels; freeze stays high until the port's ack; mem_req held until mem_ready.
//
// Ports: clk, rst (async active-low) plus the slave modport of mem_port_arbiter_if
// carrying the fetch port (i_*), data port (d_*), rdata, freeze and the memory side (mem_*).
// Optional feature: define ARB_IBUF_EN to add a one-entry instruction buffer that
// answers repeat fetches of the same word without touching memory.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_LEN     = ADDR_LEN_DEF,
    parameter int MEM_ADDR_LEN = mem_addr_len(ADDR_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    arb_state_e              state_q, state_d;
    logic [MEM_ADDR_LEN-1:0] addr_q,  addr_d;   // word address of the access in flight
    logic                    we_q,    we_d;
    logic [WORD_LEN-1:0]     wdata_q, wdata_d;
    logic [WORD_LEN-1:0]     rdata_q, rdata_d;

    logic [MEM_ADDR_LEN-1:0] i_word;
    logic [MEM_ADDR_LEN-1:0] d_word;
    logic [3:0]              byte_ofs_unused;

    assign i_word          = bus.i_addr[ADDR_LEN-1:BYTE_OFS_LEN];
    assign d_word          = bus.d_addr[ADDR_LEN-1:BYTE_OFS_LEN];
    // Memory is word addressed; the byte offsets carry no information here.
    assign byte_ofs_unused = {bus.i_addr[BYTE_OFS_LEN-1:0], bus.d_addr[BYTE_OFS_LEN-1:0]};

`ifdef ARB_IBUF_EN
    logic                ibuf_hit;
    logic [WORD_LEN-1:0] ibuf_dat;
    logic                ibuf_fill_vld;
    logic                ibuf_inv_vld;

    assign ibuf_fill_vld = (state_q == I_ACC) && bus.mem_ready;
    assign ibuf_inv_vld  = (state_q == D_ACC) && bus.mem_ready && we_q;

    arb_ibuf #(
        .TAG_LEN    (MEM_ADDR_LEN)
    ) u_ibuf (
        .clk        (clk),
        .rst        (rst),
        .fill_vld   (ibuf_fill_vld),
        .fill_tag   (addr_q),
        .fill_dat   (bus.mem_rdata),
        .inv_vld    (ibuf_inv_vld),
        .inv_tag    (addr_q),
        .lookup_tag (i_word),
        .hit        (ibuf_hit),
        .hit_dat    (ibuf_dat)
    );
`endif

    // Next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                // Data port wins: its instruction is older (already in MEM).
                if (bus.d_req) begin
                    state_d = D_ACC;
                    addr_d  = d_word;
                    we_d    = bus.d_we;
                    wdata_d = bus.d_wdata;
                end else if (bus.i_req) begin
                    addr_d = i_word;
                    we_d   = 1'b0;
`ifdef ARB_IBUF_EN
                    if (ibuf_hit) begin
                        state_d = I_RESP;
                        rdata_d = ibuf_dat;
                    end else begin
                        state_d = I_ACC;
                    end
`else
                    state_d = I_ACC;
`endif
                end
            end

            D_ACC: begin
                if (bus.mem_ready) begin
                    // Stores leave the last read value on rdata.
                    if (!we_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                    state_d = D_RESP;
                end
            end

            I_ACC: begin
                if (bus.mem_ready) begin
                    rdata_d = bus.mem_rdata;
                    state_d = I_RESP;
                end
            end

            // Ack lasts exactly one cycle; IDLE then re-samples both ports.
            D_RESP:  state_d = IDLE;
            I_RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset also abandons any access in flight: mem_req drops immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory side is driven straight from the latched access, so requester
    // changes during an access cannot leak onto the memory bus.
    assign bus.mem_req   = (state_q == D_ACC) || (state_q == I_ACC);
    assign bus.mem_we    = (state_q == D_ACC) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.i_ack     = (state_q == I_RESP);
    assign bus.d_ack     = (state_q == D_RESP);
    assign bus.rdata     = rdata_q;

    // Low in the ack cycle so the pipeline advances on that edge.
    assign bus.freeze    = (bus.i_req & ~bus.i_ack) | (bus.d_req & ~bus.d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter against a transaction-level model.
// Latency: n/a (bench).
// Backpressure: bench plays both requesters and a backing memory with random latency.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int AL  = 32;
    localparam int MAL = 30;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_LEN(AL), .MEM_ADDR_LEN(MAL)) bus();

    mem_port_arbiter #(
        .ADDR_LEN     (AL),
        .MEM_ADDR_LEN (MAL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard queues ----------------
    typedef struct packed {
        logic        is_d;
        logic [31:0] dat;
        logic        hit;
    } ack_exp_t;

    typedef struct packed {
        logic        we;
        logic [29:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    ack_exp_t ack_q[$];
    mem_exp_t mem_q[$];

    // ---------------- reference model state ----------------
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] env_mem [int unsigned];
    logic [31:0] m_rdata   = '0;
    bit          m_ib_vld  = 0;
    logic [29:0] m_ib_tag  = '0;

    function automatic logic [31:0] dflt(input int unsigned w);
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [29:0] w);
        int unsigned k = 32'(w);
        if (ref_mem.exists(k)) return ref_mem[k];
        return dflt(k);
    endfunction

    function automatic logic [31:0] env_rd(input logic [29:0] w);
        int unsigned k = 32'(w);
        if (env_mem.exists(k)) return env_mem[k];
        return dflt(k);
    endfunction

    // ---------------- backing memory responder ----------------
    int force_k  = 0;
    bit spur_req = 0;
    bit busy     = 0;
    int cnt      = 0;

    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            bus.mem_ready = 1'b0;
            bus.mem_rdata = $urandom;
            if (!rst) begin
                busy = 0;
            end else begin
                if (spur_req && !bus.mem_req && !busy) begin
                    bus.mem_ready = 1'b1;
                    spur_req      = 0;
                end
                if (bus.mem_req && !busy) begin
                    busy = 1;
                    cnt  = ((force_k > 0) ? force_k : int'($urandom_range(1, 5))) - 1;
                end else if (busy) begin
                    check("mem_req_held", {31'd0, bus.mem_req}, 32'd1);
                    if (!bus.mem_req) busy = 0;
                end
                if (busy) begin
                    if (cnt == 0) begin
                        bus.mem_ready = 1'b1;
                        if (bus.mem_we) env_mem[32'(bus.mem_addr)] = bus.mem_wdata;
                        else            bus.mem_rdata = env_rd(bus.mem_addr);
                        busy = 0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    bit mem_seen = 0;
    int last_rdy = -10;

    initial begin
        ack_exp_t a;
        mem_exp_t m;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mem_seen = 0;
            end else begin
                check("freeze", {31'd0, bus.freeze},
                      {31'd0, (bus.i_req & ~bus.i_ack) | (bus.d_req & ~bus.d_ack)});
                if (bus.mem_req && !mem_seen) begin
                    mem_seen = 1;
                    if (mem_q.size() == 0) begin
                        check("unexpected_mem_req", 32'd1, 32'd0);
                    end else begin
                        m = mem_q.pop_front();
                        check("mem_we",   {31'd0, bus.mem_we}, {31'd0, m.we});
                        check("mem_addr", {2'd0, bus.mem_addr}, {2'd0, m.addr});
                        if (m.we) check("mem_wdata", bus.mem_wdata, m.wdata);
                    end
                end else if (!bus.mem_req) begin
                    mem_seen = 0;
                end
                if (bus.mem_ready && bus.mem_req) last_rdy = cyc;
                if (bus.i_ack && bus.d_ack) check("dual_ack", 32'd1, 32'd0);
                if (bus.i_ack || bus.d_ack) begin
                    if (ack_q.size() == 0) begin
                        check("unexpected_ack", 32'd1, 32'd0);
                    end else begin
                        a = ack_q.pop_front();
                        check("ack_port_is_d", {31'd0, bus.d_ack}, {31'd0, a.is_d});
                        check(a.is_d ? "d_rdata" : "i_rdata", bus.rdata, a.dat);
                        if (!a.hit) check("ack_after_ready", 32'(cyc - last_rdy), 32'd1);
                    end
                end
            end
        end
    end

    // ---------------- one access episode (one or both ports) ----------------
    task automatic episode(input bit do_i, input logic [31:0] ia,
                           input bit do_d, input bit dwe,
                           input logic [31:0] da, input logic [31:0] dwd);
        ack_exp_t    a;
        mem_exp_t    m;
        logic [29:0] w;
        bit          i_hit = 0;
        bit          i_done, d_done, i_drop, d_drop;
        int          c0, i_cyc, d_cyc;

        // Model: data port first, then the fetch sees memory after that data access.
        if (do_d) begin
            w = da[31:2];
            m = '{we: dwe, addr: w, wdata: dwd};
            mem_q.push_back(m);
            if (dwe) begin
                ref_mem[32'(w)] = dwd;
                if (m_ib_vld && m_ib_tag == w) m_ib_vld = 0;
            end else begin
                m_rdata = ref_rd(w);
            end
            a = '{is_d: 1'b1, dat: m_rdata, hit: 1'b0};
            ack_q.push_back(a);
        end
        if (do_i) begin
            w = ia[31:2];
`ifdef ARB_IBUF_EN
            i_hit = m_ib_vld && (m_ib_tag == w);
`endif
            if (!i_hit) begin
                m = '{we: 1'b0, addr: w, wdata: 32'd0};
                mem_q.push_back(m);
            end
            m_rdata = ref_rd(w);
            a = '{is_d: 1'b0, dat: m_rdata, hit: i_hit};
            ack_q.push_back(a);
`ifdef ARB_IBUF_EN
            m_ib_vld = 1;
            m_ib_tag = w;
`endif
        end

        @(posedge clk); #1;
        c0 = cyc;
        bus.i_req   = do_i;
        bus.i_addr  = ia;
        bus.d_req   = do_d;
        bus.d_we    = dwe;
        bus.d_addr  = da;
        bus.d_wdata = dwd;
        i_done = !do_i; d_done = !do_d; i_drop = 0; d_drop = 0;
        i_cyc = 0; d_cyc = 0;

        for (int t = 0; t < 80 && !(i_done && d_done); t++) begin
            @(posedge clk); #1;
            if (i_drop) begin bus.i_req = 1'b0; i_drop = 0; end
            if (d_drop) begin bus.d_req = 1'b0; d_drop = 0; end
            if (bus.i_ack && !i_done) begin i_done = 1; i_drop = 1; i_cyc = cyc; end
            if (bus.d_ack && !d_done) begin d_done = 1; d_drop = 1; d_cyc = cyc; end
            // Latched values must shield the access from requester changes.
            if (do_d && !d_done) begin
                bus.d_addr  = $urandom;
                bus.d_wdata = $urandom;
                bus.d_we    = 1'($urandom);
            end
            if (do_i && !do_d && !i_done) bus.i_addr = $urandom;
        end
        if (!(i_done && d_done)) check("ack_timeout", 32'd0, 32'd1);

        if (do_i && !do_d && i_hit)      check("hit_latency", 32'(i_cyc - c0), 32'd1);
        if (do_i && !do_d && !i_hit && force_k > 0)
            check("i_ack_latency", 32'(i_cyc - c0), 32'(force_k + 1));
        if (do_d && !do_i && force_k > 0)
            check("d_ack_latency", 32'(d_cyc - c0), 32'(force_k + 1));

        @(posedge clk); #1;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus ----------------
    initial begin
        logic [29:0] w;
        int          kind;
        logic [31:0] ia, da;

        bus.i_req = 0; bus.i_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;

        env_mem[32'h4]  = 32'h2001_0005; ref_mem[32'h4]  = 32'h2001_0005;
        env_mem[32'h80] = 32'h0000_0007; ref_mem[32'h80] = 32'h0000_0007;

        // Reset state.
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req",   {31'd0, bus.mem_req}, 32'd0);
        check("rst_mem_we",    {31'd0, bus.mem_we},  32'd0);
        check("rst_i_ack",     {31'd0, bus.i_ack},   32'd0);
        check("rst_d_ack",     {31'd0, bus.d_ack},   32'd0);
        check("rst_rdata",     bus.rdata,            32'd0);
        check("rst_mem_addr",  {2'd0, bus.mem_addr}, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata,        32'd0);
        check("rst_freeze",    {31'd0, bus.freeze},  32'd0);
        rst = 1'b1;

        // Single fetch, k=3; store, k=1; simultaneous load + fetch.
        force_k = 3; episode(1, 32'h10, 0, 0, 32'h0, 32'h0);
        force_k = 1; episode(0, 32'h0, 1, 1, 32'h100, 32'hDEAD_BEEF);
        force_k = 0; episode(1, 32'h44, 1, 0, 32'h200, 32'h0);

        // Reset in the middle of a fetch.
        force_k = 30;
        mem_q.push_back('{we: 1'b0, addr: 30'h10, wdata: 32'd0});
        @(posedge clk); #1;
        bus.i_req = 1'b1; bus.i_addr = 32'h40;
        for (int t = 0; t < 10 && !bus.mem_req; t++) @(negedge clk);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("midrst_i_ack",   {31'd0, bus.i_ack},   32'd0);
        check("midrst_d_ack",   {31'd0, bus.d_ack},   32'd0);
        check("midrst_rdata",   bus.rdata,            32'd0);
        bus.i_req = 1'b0;
        m_rdata = '0; m_ib_vld = 0;
        ack_q.delete(); mem_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        force_k = 0;
        episode(1, 32'h40, 0, 0, 32'h0, 32'h0);

        // Stray mem_ready while idle.
        spur_req = 1;
        repeat (4) begin
            @(negedge clk);
            check("spur_no_ack",  {31'd0, bus.i_ack | bus.d_ack}, 32'd0);
            check("spur_no_req",  {31'd0, bus.mem_req},           32'd0);
        end
        episode(1, 32'h14, 0, 0, 32'h0, 32'h0);

        // Repeat fetch, store to the same word, fetch again.
        episode(1, 32'h20, 0, 0, 32'h0, 32'h0);
        episode(1, 32'h20, 0, 0, 32'h0, 32'h0);
        episode(0, 32'h0, 1, 1, 32'h20, 32'hCAFE_F00D);
        episode(1, 32'h20, 0, 0, 32'h0, 32'h0);

        // Randomised traffic over a small word range to exercise reuse and conflicts.
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 2);
            w    = 30'($urandom_range(0, 15));
            ia   = {w, 2'($urandom_range(0, 3))};
            w    = 30'($urandom_range(0, 15));
            da   = {w, 2'($urandom_range(0, 3))};
            force_k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            episode(kind != 1, ia, kind != 0, 1'($urandom), da, $urandom);
        end
        force_k = 0;

        repeat (5) @(posedge clk);
        check("ack_q_drained", 32'(ack_q.size()), 32'd0);
        check("mem_q_drained", 32'(mem_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
